// File: rtl/input_stream_gearbox_pkg.sv
// Shared array-dimension and stream-width constants for the activation path
// (gearbox, controller and weight buffer).
package input_stream_gearbox_pkg;

  localparam int unsigned ARRAY_ROWS     = 12;
  localparam int unsigned ARRAY_COLS     = 12;
  localparam int unsigned ACT_W          = 8;
  localparam int unsigned DEF_STREAM_W   = 64;
  localparam int unsigned DEF_ROW_BYTES  = ARRAY_COLS;
  localparam int unsigned CNT_W          = 16;

  typedef logic [ACT_W-1:0] act_t;

  // Bits needed to hold a byte count in the range 0..n.
  function automatic int unsigned fill_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter16
  import input_stream_gearbox_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/input_stream_gearbox.sv
// Repacks IN_W-bit DMA activation words into ROW_BYTES-wide systolic-array rows,
// one row per cycle while the controller requests them.
module input_stream_gearbox
  import input_stream_gearbox_pkg::*;
#(
  parameter int unsigned IN_W      = DEF_STREAM_W,
  parameter int unsigned ROW_BYTES = DEF_ROW_BYTES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IN_W-1:0]        s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   i_stream_en,
  input  logic                   i_flush,
  output logic [8*ROW_BYTES-1:0] o_row,
  output logic                   o_input_valid,
  output logic [CNT_W-1:0]       o_row_cnt,
  output logic [CNT_W-1:0]       o_starve_cnt
);

  localparam int unsigned WB  = IN_W / 8;
  localparam int unsigned SB  = 2 * ROW_BYTES;
  localparam int unsigned SBW = 8 * SB;
  localparam int unsigned RW  = 8 * ROW_BYTES;
  localparam int unsigned FW  = fill_w(SB);

  logic [SBW-1:0] stage_q, stage_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic [RW-1:0]  row_q, row_d;
  logic           valid_q, valid_d;

  logic           accept_c, emit_c, starve_c;
  logic [31:0]    base_c, fill_sum_c;
  logic [SBW-1:0] shifted_c, ins_c, mask_c;

  // Ready depends only on the registered fill so it never loops back through tvalid.
  assign s_axis_tready = (fill_q <= FW'(SB - WB));
  assign accept_c      = s_axis_tvalid && s_axis_tready;
  assign emit_c        = i_stream_en && (fill_q >= FW'(ROW_BYTES));
  assign starve_c      = i_stream_en && !emit_c;

  // Pop a row from the bottom, then drop the new word right after whatever remains.
  always_comb begin
    stage_d    = stage_q;
    fill_d     = fill_q;
    row_d      = row_q;
    valid_d    = 1'b0;
    shifted_c  = emit_c ? (stage_q >> RW) : stage_q;
    base_c     = 32'(fill_q) - (emit_c ? ROW_BYTES : 32'd0);
    ins_c      = SBW'(s_axis_tdata) << (8 * base_c);
    mask_c     = SBW'({IN_W{1'b1}}) << (8 * base_c);
    fill_sum_c = 32'(fill_q) + (accept_c ? WB : 32'd0) - (emit_c ? ROW_BYTES : 32'd0);

    if (i_flush) begin
      stage_d = '0;
      fill_d  = '0;
    end else begin
      stage_d = accept_c ? ((shifted_c & ~mask_c) | ins_c) : shifted_c;
      fill_d  = FW'(fill_sum_c);
      if (emit_c) begin
        row_d   = stage_q[RW-1:0];
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      fill_q  <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
      row_q   <= row_d;
      valid_q <= valid_d;
    end
  end

  sat_counter16 u_row_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (i_flush),
    .inc_i (emit_c),
    .cnt_o (o_row_cnt)
  );

  sat_counter16 u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (i_flush),
    .inc_i (starve_c),
    .cnt_o (o_starve_cnt)
  );

  assign o_row         = row_q;
  assign o_input_valid = valid_q;

endmodule

// File: doc/input_stream_gearbox.md
INPUT_STREAM_GEARBOX -- requirements
Module: input_stream_gearbox

Interface
REQ-001 SHALL have parameter IN_W, default 64, meaning input stream word width in bits (8 int8 activations).
REQ-002 SHALL have parameter ROW_BYTES, default 12, meaning activation bytes per systolic-array row (output width 8*ROW_BYTES).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_axis_tdata  input  IN_W  DMA activation word; byte 0 = bits [7:0] = oldest byte.
REQ-006 SHALL have port s_axis_tvalid  input  1  word valid.
REQ-007 SHALL have port s_axis_tready  output  1  word accepted when tvalid && tready.
REQ-008 SHALL have port i_stream_en  input  1  controller request for one row per cycle (ctrl_input_stream_en).
REQ-009 SHALL have port i_flush  input  1  synchronous clear of staged data and counters.
REQ-010 SHALL have port o_row  output  8*ROW_BYTES  row to array; row byte k = bits [8k+7:8k].
REQ-011 SHALL have port o_input_valid  output  1  o_row valid this cycle; drives controller i_input_valid.
REQ-012 SHALL have port o_row_cnt  output  16  rows emitted since reset/flush.
REQ-013 SHALL have port o_starve_cnt  output  16  cycles i_stream_en high with no row emitted.

Function
REQ-014 SHALL keep a byte staging register of 2*ROW_BYTES bytes and fill count F (bytes, 0..2*ROW_BYTES).
REQ-015 SHALL drive s_axis_tready = (F <= 2*ROW_BYTES - IN_W/8), combinational from registered F only (no dependence on tvalid or i_stream_en).
REQ-016 SHALL append accepted word bytes after the F staged bytes, preserving byte order.
REQ-017 SHALL emit a row when i_stream_en && F >= ROW_BYTES: staged bytes 0..ROW_BYTES-1 registered into o_row, o_input_valid high the next cycle (latency 1).
REQ-018 SHALL, on emit, shift remaining staged bytes down by ROW_BYTES.
REQ-019 SHALL allow accept and emit in the same cycle: F_next = F + (IN_W/8)*accept - ROW_BYTES*emit; appended bytes land after the shifted remainder.
REQ-020 SHALL hold o_row unchanged and drive o_input_valid low in cycles following no emit.
REQ-021 SHALL increment o_row_cnt per emit, saturating at 16'hFFFF.
REQ-022 SHALL increment o_starve_cnt, saturating, each cycle i_stream_en && F < ROW_BYTES.
REQ-023 SHALL, on i_flush, set F=0, clear both counters, drive o_input_valid low next cycle, and ignore same-cycle accept/emit (tready still reflects pre-flush F; a beat accepted that cycle is dropped).
REQ-024 SHALL not emit when i_stream_en is low, regardless of F.
REQ-025 SHALL require 2*ROW_BYTES >= ROW_BYTES + IN_W/8 - 1 and IN_W multiple of 8; other parameter sets unsupported.

Reset
REQ-026 SHALL on rst_n low asynchronously set F=0, o_row=0, o_input_valid=0, o_row_cnt=0, o_starve_cnt=0, hence s_axis_tready=1 after reset.
REQ-027 SHALL discard all staged data if reset asserts mid-operation; no partial row emitted after release.

Structure
REQ-028 SHALL take IN_W and ROW_BYTES defaults from a shared package holding array-dimension and stream-width constants, also used by the controller and weight buffer.
REQ-029 SHALL be a single module; the saturating 16-bit counter MAY be a sub-module named sat_counter16.

Verification
REQ-030 Three words 0x0706050403020100, 0x0F0E..08, 0x1716..10 with i_stream_en high -> two rows 0x0B0A..00 then 0x1716..0C, o_row_cnt=2, no gaps in byte order.
REQ-031 i_stream_en high with no input for 5 cycles -> o_input_valid stays 0, o_starve_cnt=5, o_row_cnt=0.
REQ-032 i_stream_en low, continuous tvalid -> tready drops after 3 words (F=24), F holds 24; enabling stream then emits 2 rows back-to-back.
REQ-033 Continuous tvalid and i_stream_en for 30 cycles -> steady 2 rows per 3 words, F never exceeds 24, no byte loss/duplication.
REQ-034 i_flush with F=20 -> next cycle F=0, tready=1, counters 0, no o_input_valid pulse.
REQ-035 rst_n pulsed low mid-stream (F=16, emit pending) -> all outputs 0 asynchronously, first row after release built only from post-reset words.
